// File: rtl/sd_path_arbiter.sv
// sd_path_arbiter: shares the core's SPI SD master between the physical card and the VHD-backed sd_card,
// switching only at transaction boundaries. Define SD_ARB_MOUNT_RESET_EN for the reset-after-mount pulse.
module sd_path_arbiter #(
   parameter int IDLE_CYCLES    = 16,
   parameter int SWITCH_TIMEOUT = 1000000,
   parameter int DRAIN_CYCLES   = 8,
   parameter int ACT_HOLD       = 1000000
) (
   input  logic clk_sys,
   input  logic reset,
   input  logic img_mounted,
   input  logic img_nz,
   input  logic rst_on_mount,
   input  logic core_sck,
   input  logic core_mosi,
   input  logic core_ss,
   output logic core_miso,
   output logic vsd_sck,
   output logic vsd_mosi,
   output logic vsd_ss,
   input  logic vsd_miso,
   output logic SD_SCK,
   output logic SD_MOSI,
   output logic SD_CS,
   input  logic SD_MISO,
   output logic vsd_sel,
   output logic sw_pending,
   output logic sw_forced,
   output logic sd_act,
   output logic reset_req
);

   localparam int IW = $clog2(IDLE_CYCLES + 1);
   localparam int TW = $clog2(SWITCH_TIMEOUT + 1);
   localparam int DW = $clog2(DRAIN_CYCLES + 1);
   localparam int AW = $clog2(ACT_HOLD + 1);
   localparam logic [IW-1:0] IDLE_LAST  = IW'(IDLE_CYCLES - 1);
   localparam logic [TW-1:0] TO_LAST    = TW'(SWITCH_TIMEOUT - 1);
   localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
   localparam logic [AW-1:0] ACT_MAX    = AW'(ACT_HOLD);

   typedef enum logic [1:0] {PHYS, VIRT, DRAIN} state_t;

   state_t        state, state_nxt;
   logic          target;
   logic [IW-1:0] idle_cnt;
   logic [TW-1:0] to_cnt;
   logic [DW-1:0] drain_cnt;
   logic [AW-1:0] act_cnt;
   logic          mosi_q, miso_q;
   logic          idle_hit, to_hit, drain_go, commit, same_tgt;

   assign idle_hit = sw_pending && (state != DRAIN) && core_ss && (idle_cnt == IDLE_LAST);
   assign to_hit   = sw_pending && (state != DRAIN) && (to_cnt == TO_LAST);
   assign drain_go = idle_hit || to_hit;
   assign commit   = (state == DRAIN) && (drain_cnt == DRAIN_LAST);
   assign same_tgt = img_mounted && (img_nz == vsd_sel);

   always_ff @(posedge clk_sys) begin
      if (reset) state <= PHYS;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         PHYS, VIRT: if (drain_go) state_nxt = DRAIN;
         DRAIN:      if (commit)   state_nxt = target ? VIRT : PHYS;
         default:    state_nxt = PHYS;
      endcase
   end

   always_comb begin
      // NOTE: every output gets a default first so no path through the case can infer a latch.
      SD_SCK    = 1'b0;
      SD_MOSI   = 1'b0;
      SD_CS     = 1'b1;
      vsd_sck   = 1'b0;
      vsd_mosi  = 1'b0;
      vsd_ss    = 1'b1;
      core_miso = 1'b1;
      unique case (state)
         PHYS: begin
            SD_SCK    = core_sck;
            SD_MOSI   = core_mosi;
            SD_CS     = core_ss;
            core_miso = SD_MISO;
         end
         VIRT: begin
            vsd_sck   = core_sck;
            vsd_mosi  = core_mosi;
            vsd_ss    = core_ss;
            core_miso = vsd_miso;
         end
         default: ;
      endcase
   end

   // Request tracking: a mount pulse always applies its rule to sw_pending, even mid-drain.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         vsd_sel    <= 1'b0;
         target     <= 1'b0;
         sw_pending <= 1'b0;
         sw_forced  <= 1'b0;
         idle_cnt   <= '0;
         to_cnt     <= '0;
         drain_cnt  <= '0;
      end else begin
         sw_forced <= to_hit && !idle_hit;
         drain_cnt <= (state == DRAIN && !commit) ? drain_cnt + 1'b1 : '0;
         if (img_mounted) target <= img_nz;

         if (commit) begin
            vsd_sel    <= target;
            sw_pending <= img_mounted && (img_nz != target);
         end else if (img_mounted) begin
            sw_pending <= !same_tgt;
         end

         if (commit || state == DRAIN || drain_go || same_tgt || !sw_pending) begin
            idle_cnt <= '0;
            to_cnt   <= '0;
         end else begin
            to_cnt   <= to_cnt + 1'b1;
            idle_cnt <= core_ss ? idle_cnt + 1'b1 : '0;
         end
      end
   end

   // NOTE: the edge-detect samplers are deliberately not reset, so reset itself never looks like bus activity.
   always_ff @(posedge clk_sys) begin
      mosi_q <= core_mosi;
      miso_q <= core_miso;
   end

   always_ff @(posedge clk_sys) begin
      if (reset)                                            act_cnt <= ACT_MAX;
      else if ((core_mosi != mosi_q) || (core_miso != miso_q)) act_cnt <= '0;
      else if (act_cnt != ACT_MAX)                           act_cnt <= act_cnt + 1'b1;
   end

   assign sd_act = (act_cnt < ACT_MAX);

`ifdef SD_ARB_MOUNT_RESET_EN
   always_ff @(posedge clk_sys) begin
      if (reset) reset_req <= 1'b0;
      else       reset_req <= commit && rst_on_mount && (target != vsd_sel);
   end
`else
   logic unused_rst_on_mount;
   assign unused_rst_on_mount = rst_on_mount;
   assign reset_req = 1'b0;
`endif

endmodule

// File: tb/tb_sd_path_arbiter.sv
// tb_sd_path_arbiter: directed switch scenarios under random SPI traffic, with routing, switch timing
// and the activity LED predicted from the block's rules by a small reference model.
module tb_sd_path_arbiter;

   localparam int IDLE = 16;
   localparam int TMO  = 100;
   localparam int DRN  = 8;
   localparam int HOLD = 50;
   localparam int M_PHYS = 0, M_VIRT = 1, M_DRAIN = 2;

`ifdef SD_ARB_MOUNT_RESET_EN
   localparam bit RREQ_EN = 1'b1;
`else
   localparam bit RREQ_EN = 1'b0;
`endif

   logic clk_sys = 1'b0, reset = 1'b1;
   logic img_mounted = 1'b0, img_nz = 1'b0, rst_on_mount = 1'b1;
   logic core_sck = 1'b0, core_mosi = 1'b0, core_ss = 1'b1;
   logic vsd_miso = 1'b0, SD_MISO = 1'b0;
   logic core_miso, vsd_sck, vsd_mosi, vsd_ss, SD_SCK, SD_MOSI, SD_CS;
   logic vsd_sel, sw_pending, sw_forced, sd_act, reset_req;

   int     n_vec = 0, n_err = 0;
   longint edge_n = 0, last_chg = -1000;
   logic   prev_mosi = 1'b0, prev_miso = 1'b0;
   int     cur_mode = M_PHYS;
   bit     traffic = 1'b1;
   logic   rreq_exp;

   sd_path_arbiter #(
      .IDLE_CYCLES(IDLE), .SWITCH_TIMEOUT(TMO), .DRAIN_CYCLES(DRN), .ACT_HOLD(HOLD)
   ) dut (
      .clk_sys(clk_sys), .reset(reset), .img_mounted(img_mounted), .img_nz(img_nz),
      .rst_on_mount(rst_on_mount), .core_sck(core_sck), .core_mosi(core_mosi), .core_ss(core_ss),
      .core_miso(core_miso), .vsd_sck(vsd_sck), .vsd_mosi(vsd_mosi), .vsd_ss(vsd_ss),
      .vsd_miso(vsd_miso), .SD_SCK(SD_SCK), .SD_MOSI(SD_MOSI), .SD_CS(SD_CS), .SD_MISO(SD_MISO),
      .vsd_sel(vsd_sel), .sw_pending(sw_pending), .sw_forced(sw_forced), .sd_act(sd_act),
      .reset_req(reset_req)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic check(input string tag, input logic obs, input logic exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s edge=%0d got=%b want=%b", tag, edge_n, obs, exp);
      end
   endtask

   function automatic logic miso_for(input int mode);
      if (mode == M_PHYS)      return SD_MISO;
      else if (mode == M_VIRT) return vsd_miso;
      else                     return 1'b1;
   endfunction

   // Routing table: the selected target mirrors the core, the other is parked deselected.
   task automatic check_route(input int mode);
      logic e_sck, e_mosi, e_cs, v_sck, v_mosi, v_ss;
      e_sck = 1'b0; e_mosi = 1'b0; e_cs = 1'b1;
      v_sck = 1'b0; v_mosi = 1'b0; v_ss = 1'b1;
      if (mode == M_PHYS) begin
         e_sck = core_sck; e_mosi = core_mosi; e_cs = core_ss;
      end else if (mode == M_VIRT) begin
         v_sck = core_sck; v_mosi = core_mosi; v_ss = core_ss;
      end
      check("SD_SCK", SD_SCK, e_sck);
      check("SD_MOSI", SD_MOSI, e_mosi);
      check("SD_CS", SD_CS, e_cs);
      check("vsd_sck", vsd_sck, v_sck);
      check("vsd_mosi", vsd_mosi, v_mosi);
      check("vsd_ss", vsd_ss, v_ss);
      check("core_miso", core_miso, miso_for(mode));
   endtask

   // One clock: drive traffic, check routing, clock, then check the state expected after the edge.
   task automatic tick(input int mode, input logic sel, input logic pend,
                       input logic forced, input logic rreq);
      logic s_mosi, s_miso;
      if (traffic) begin
         core_sck  = 1'($urandom_range(0, 1));
         core_mosi = 1'($urandom_range(0, 1));
         SD_MISO   = 1'($urandom_range(0, 1));
         vsd_miso  = 1'($urandom_range(0, 1));
      end
      #1;
      check_route(cur_mode);
      s_mosi = core_mosi;
      s_miso = miso_for(cur_mode);
      @(posedge clk_sys);
      #1;
      edge_n++;
      if (reset) last_chg = edge_n - HOLD;
      else if (s_mosi !== prev_mosi || s_miso !== prev_miso) last_chg = edge_n;
      prev_mosi = s_mosi;
      prev_miso = s_miso;
      cur_mode  = mode;
      check("vsd_sel", vsd_sel, sel);
      check("sw_pending", sw_pending, pend);
      check("sw_forced", sw_forced, forced);
      check("reset_req", reset_req, rreq);
      check("sd_act", sd_act, logic'((edge_n - last_chg) < HOLD));
      check_route(cur_mode);
   endtask

   task automatic run(input int n, input int mode, input logic sel, input logic pend);
      for (int i = 0; i < n; i++) tick(mode, sel, pend, 1'b0, 1'b0);
   endtask

   task automatic pulse(input logic nz, input int mode, input logic sel, input logic pend);
      img_mounted = 1'b1;
      img_nz      = nz;
      tick(mode, sel, pend, 1'b0, 1'b0);
      img_mounted = 1'b0;
   endtask

   initial begin
      rreq_exp = RREQ_EN & rst_on_mount;
      @(posedge clk_sys);
      #1;
      run(3, M_PHYS, 1'b0, 1'b0);                 // reset held: PHYS, everything idle, sd_act=0
      reset = 1'b0;

      // Physical card carries a transfer after reset.
      core_ss = 1'b0;
      run(20, M_PHYS, 1'b0, 1'b0);

      // Idle-bus switch to the virtual card: DRAIN at +16, commit at +24.
      core_ss = 1'b1;
      pulse(1'b1, M_PHYS, 1'b0, 1'b1);
      run(IDLE - 1, M_PHYS, 1'b0, 1'b1);
      run(DRN, M_DRAIN, 1'b0, 1'b1);
      tick(M_VIRT, 1'b1, 1'b0, 1'b0, rreq_exp);
      core_ss = 1'b0;
      run(12, M_VIRT, 1'b1, 1'b0);

      // Busy bus back to physical: short idle gap does not qualify, timeout forces at +100.
      pulse(1'b0, M_VIRT, 1'b1, 1'b1);
      run(20, M_VIRT, 1'b1, 1'b1);
      core_ss = 1'b1;
      run(10, M_VIRT, 1'b1, 1'b1);
      core_ss = 1'b0;
      run(TMO - 31, M_VIRT, 1'b1, 1'b1);
      tick(M_DRAIN, 1'b1, 1'b1, 1'b1, 1'b0);
      run(DRN - 1, M_DRAIN, 1'b1, 1'b1);
      tick(M_PHYS, 1'b0, 1'b0, 1'b0, rreq_exp);
      run(5, M_PHYS, 1'b0, 1'b0);

      // Request overwritten mid-drain: returns to PHYS with no reset request.
      core_ss = 1'b1;
      pulse(1'b1, M_PHYS, 1'b0, 1'b1);
      run(IDLE - 1, M_PHYS, 1'b0, 1'b1);
      run(3, M_DRAIN, 1'b0, 1'b1);
      pulse(1'b0, M_DRAIN, 1'b0, 1'b0);
      run(DRN - 4, M_DRAIN, 1'b0, 1'b0);
      tick(M_PHYS, 1'b0, 1'b0, 1'b0, 1'b0);
      run(4, M_PHYS, 1'b0, 1'b0);

      // Request cancelled before the boundary: no drain ever happens.
      pulse(1'b1, M_PHYS, 1'b0, 1'b1);
      run(5, M_PHYS, 1'b0, 1'b1);
      pulse(1'b0, M_PHYS, 1'b0, 1'b0);
      run(IDLE + DRN, M_PHYS, 1'b0, 1'b0);

      // Reset in the middle of a drain, then a quiet bus lets the activity LED expire.
      pulse(1'b1, M_PHYS, 1'b0, 1'b1);
      run(IDLE - 1, M_PHYS, 1'b0, 1'b1);
      run(3, M_DRAIN, 1'b0, 1'b1);
      reset = 1'b1;
      tick(M_PHYS, 1'b0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      traffic   = 1'b0;
      core_mosi = ~core_mosi;
      tick(M_PHYS, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < HOLD + 8; i++) begin
         core_ss = 1'(i % 3 == 0);
         tick(M_PHYS, 1'b0, 1'b0, 1'b0, 1'b0);
      end

      // Random traffic with random selects on the physical path.
      traffic = 1'b1;
      for (int i = 0; i < 200; i++) begin
         core_ss = 1'($urandom_range(0, 1));
         if (i == 120) traffic = 1'b0;
         tick(M_PHYS, 1'b0, 1'b0, 1'b0, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
